debounce_sync: RTL and testbench
================================

# debounce_sync

Input conditioning stage for asynchronous signals (push-buttons, switches, external strobes). Synchronises a raw pin into the `ck` domain, rejects glitches shorter than a programmable stable time and produces a clean registered level plus single-cycle edge pulses. Sits directly upstream of the design's D flip-flops and registers: `q` drives their `d` inputs, and `rise`/`fall` serve as clean enables or triggers.

## Interface
- `STABLE_CYCLES`, default 50000: number of consecutive synchronised samples, in addition to the first differing sample, that are required before `q` changes. Legal range is 1 ≤ `STABLE_CYCLES` ≤ 2^`CNT_W` − 1. Out-of-range values are an elaboration error.
- `CNT_W`, default 16: stability counter width.
- `ck`  input  1  system clock, rising-edge active.
- `reset`  input  1  asynchronous, active-low reset: 0 resets the block immediately, with no clock required.
- `d_in`  input  1  raw asynchronous input.
- `q`  output  1  debounced level, registered.
- `rise`  output  1  one-cycle pulse when `q` goes 0→1, registered.
- `fall`  output  1  one-cycle pulse when `q` goes 1→0, registered.
- `busy`  output  1  high while a candidate transition is being qualified, registered.

## Operation
- **Synchroniser:** two-flop chain `s1` ← `d_in`, `s2` ← `s1`. Only `s2` is used downstream.
- **FSM states:**
  - IDLE_LOW: `q`=0.
  - WAIT_HIGH: `q`=0, `busy`=1.
  - IDLE_HIGH: `q`=1.
  - WAIT_LOW: `q`=1, `busy`=1.
- **IDLE_LOW:**
  - `s2`=1 → WAIT_HIGH, `cnt`←0.
  - Otherwise stay.
- **WAIT_HIGH:**
  - `s2`=0 → IDLE_LOW, `cnt`←0. This is glitch rejection; no pulse is issued.
  - `s2`=1 and `cnt`==`STABLE_CYCLES`−1 → IDLE_HIGH, `q`←1, `rise`←1.
  - `s2`=1 otherwise → `cnt`←`cnt`+1.
- **IDLE_HIGH / WAIT_LOW:** mirror of the two states above with polarities swapped. Qualified transition sets `q`←0, `fall`←1.
- **Pulses:** `rise` and `fall` default to 0 every cycle and are never high simultaneously.
- **Counter:** `cnt` is unsigned `CNT_W` bits and never wraps. The comparison against `STABLE_CYCLES`−1 ends the count first.
- **Bounce during WAIT:** any contrary sample restarts qualification from the IDLE state. There is no partial credit.
- **`busy`:** equals (state==WAIT_HIGH || state==WAIT_LOW), registered with the state.

## Timing
- **Reset values** (asynchronous, while `reset`=0): `s1`=0, `s2`=0, state=IDLE_LOW, `cnt`=0, `q`=0, `rise`=0, `fall`=0, `busy`=0.
- **Reset release:** the first active edge is the first rising `ck` with `reset`=1.
- **Reset with `d_in` high:** if `d_in` is already 1 at release, a full qualification runs. `rise` pulses once; the input is not treated as already high.
- **Latency:** let E0 be the first edge sampling a new `d_in` value that then stays stable.
  - `s2` updates at E1.
  - FSM enters WAIT at E2.
  - `q` and the pulse update at E(`STABLE_CYCLES`+2).
  - The pulse clears at E(`STABLE_CYCLES`+3).
- **Minimum rejected glitch:** any `d_in` pulse shorter than `STABLE_CYCLES`+1 sampled cycles never changes `q`.
- **Mid-WAIT reset:** assertion during WAIT_x aborts immediately. No pulse is issued and `q` returns to 0 even from WAIT_LOW/IDLE_HIGH.
- **Return to idle:** at most one pulse per qualified transition. The FSM returns to IDLE the same edge the pulse is set.

## Test plan
Bench parameters: `STABLE_CYCLES`=4, `CNT_W`=4 unless noted.
1. **Reset:** drive `reset`=0 mid-cycle with `q`=1 → all outputs 0 before the next `ck` edge. After release with `d_in`=0 for 20 cycles → `q`=0, no pulses.
2. **Clean rise:** `d_in` 0→1 sampled at E0, held → `busy`=1 after E2, `q`=1 and `rise`=1 after E6, `rise`=0 after E7. `fall` stays 0 throughout.
3. **Glitch rejection:** `d_in`=1 for 4 sampled cycles, then 0 → `q` stays 0, `rise` never asserts, `busy` returns to 0 two cycles after the drop.
4. **Bounce then settle:** pattern 1,0,1,1,0 followed by steady 1 → `q` rises exactly once, 6 edges after the final 0→1 sample, with one `rise` pulse.
5. **Clean fall and reset mid-WAIT:** from `q`=1, drop `d_in` → `fall` pulse after E6.
   - Repeat the fall, but assert `reset` at E4 → `q`=0 immediately, no `fall` pulse, state IDLE_LOW.
6. **Boundary parameters:**
   - `STABLE_CYCLES`=1: a 2-cycle pulse toggles `q`; a 1-cycle pulse does not.
   - `STABLE_CYCLES`=15, `CNT_W`=4: rise after E17 with no counter wrap.

Source files
------------

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a stability-qualifying FSM.
// Outputs a clean registered level `q` and single-cycle `rise`/`fall` pulses.
module debounce_sync #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic ck,
  input  logic reset,
  input  logic d_in,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_param
    $error("debounce_sync: STABLE_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  logic             s1, s2;
  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             q_n, rise_n, fall_n;

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d_in;
      s2 <= s1;
    end
  end

  // Any contrary sample during WAIT drops straight back to IDLE: no partial credit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    q_n     = q;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (s2) begin
          state_n = WAIT_HIGH;
          cnt_n   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_n = IDLE_LOW;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = IDLE_HIGH;
          cnt_n   = '0;
          q_n     = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s2) begin
          state_n = WAIT_LOW;
          cnt_n   = '0;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_n = IDLE_HIGH;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = IDLE_LOW;
          cnt_n   = '0;
          q_n     = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE_LOW;
        cnt_n   = '0;
        q_n     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      q     <= q_n;
      rise  <= rise_n;
      fall  <= fall_n;
      busy  <= (state_n == WAIT_HIGH) || (state_n == WAIT_LOW);
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Randomised bench for debounce_sync: three instances (STABLE_CYCLES 4, 1, 15)
// share one input and are compared every cycle against a run-length model.
module tb_debounce_sync;
  localparam int N = 3;
  localparam int SC [N] = '{4, 1, 15};

  logic ck = 1'b0;
  logic reset = 1'b0;
  logic d_in = 1'b0;
  logic [N-1:0] q, rise, fall, busy;

  int checks = 0;
  int errors = 0;

  // model: FSM sees the input delayed by two edges; q flips once the run of
  // samples differing from q reaches STABLE_CYCLES+1
  bit s1m, s2m;
  bit qm [N];
  int run [N];
  bit rm [N];
  bit fm [N];

  always #5 ck = ~ck;

  debounce_sync #(.STABLE_CYCLES(4), .CNT_W(4)) u0 (
    .ck(ck), .reset(reset), .d_in(d_in),
    .q(q[0]), .rise(rise[0]), .fall(fall[0]), .busy(busy[0]));
  debounce_sync #(.STABLE_CYCLES(1), .CNT_W(4)) u1 (
    .ck(ck), .reset(reset), .d_in(d_in),
    .q(q[1]), .rise(rise[1]), .fall(fall[1]), .busy(busy[1]));
  debounce_sync #(.STABLE_CYCLES(15), .CNT_W(4)) u2 (
    .ck(ck), .reset(reset), .d_in(d_in),
    .q(q[2]), .rise(rise[2]), .fall(fall[2]), .busy(busy[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    s1m = 1'b0;
    s2m = 1'b0;
    for (int i = 0; i < N; i++) begin
      qm[i] = 1'b0; run[i] = 0; rm[i] = 1'b0; fm[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit dv);
    for (int i = 0; i < N; i++) begin
      rm[i] = 1'b0;
      fm[i] = 1'b0;
      if (s2m != qm[i]) begin
        run[i]++;
        if (run[i] == SC[i] + 1) begin
          qm[i]  = s2m;
          rm[i]  = s2m;
          fm[i]  = !s2m;
          run[i] = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
    s2m = s1m;
    s1m = dv;
  endtask

  // Called 1 time unit after an active edge; drives d_in for the next edge.
  task automatic step(input bit dv);
    d_in = dv;
    @(posedge ck);
    model_edge(dv);
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("outs_u%0d", i), {28'd0, q[i], rise[i], fall[i], busy[i]},
          {28'd0, qm[i], rm[i], fm[i], run[i] > 0});
      chk($sformatf("pulse_excl_u%0d", i), 32'(rise[i] & fall[i]), 32'd0);
    end
  endtask

  task automatic do_reset();
    #3;
    reset = 1'b0;
    #1;
    chk("reset_async", {20'd0, q, rise, fall, busy}, 32'd0);
    model_reset();
    @(posedge ck);
    #1;
    chk("reset_hold", {20'd0, q, rise, fall, busy}, 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    bit v;
    int len;
    model_reset();
    #2;
    chk("por_outs", {20'd0, q, rise, fall, busy}, 32'd0);
    @(posedge ck);
    #1;
    reset = 1'b1;

    // idle after reset
    for (int k = 0; k < 20; k++) step(1'b0);
    chk("idle_q", 32'(q[0]), 32'd0);

    // clean rise: E0 then E1..E17
    step(1'b1);
    for (int k = 1; k <= 17; k++) begin
      step(1'b1);
      if (k == 2)  chk("rise_busy_e2", 32'(busy[0]), 32'd1);
      if (k == 3)  chk("s1_q_e3", {30'd0, q[1], rise[1]}, 32'd3);
      if (k == 5)  chk("rise_q_e5", 32'(q[0]), 32'd0);
      if (k == 6)  chk("rise_e6", {30'd0, q[0], rise[0]}, 32'd3);
      if (k == 7)  chk("rise_e7", {30'd0, q[0], rise[0]}, 32'd2);
      if (k == 16) chk("s15_q_e16", 32'(q[2]), 32'd0);
      if (k == 17) chk("s15_rise_e17", {30'd0, q[2], rise[2]}, 32'd3);
    end

    // clean fall
    step(1'b0);
    for (int k = 1; k <= 6; k++) step(1'b0);
    chk("fall_e6", {30'd0, q[0], fall[0]}, 32'd1);
    for (int k = 0; k < 20; k++) step(1'b0);

    // glitch of 4 samples: E0..E3 high, drop at E4
    for (int k = 0; k < 4; k++) step(1'b1);
    step(1'b0);
    step(1'b0);
    chk("glitch_busy_e5", 32'(busy[0]), 32'd1);
    step(1'b0);
    chk("glitch_busy_e6", {30'd0, busy[0], q[0]}, 32'd0);
    for (int k = 0; k < 10; k++) step(1'b0);

    // bounce 1,0,1,1,0 then steady 1 (final 0->1 sample is E0)
    step(1'b1); step(1'b0); step(1'b1); step(1'b1); step(1'b0);
    step(1'b1);
    for (int k = 1; k <= 6; k++) begin
      step(1'b1);
      if (k == 5) chk("bounce_q_e5", 32'(q[0]), 32'd0);
      if (k == 6) chk("bounce_rise_e6", {30'd0, q[0], rise[0]}, 32'd3);
    end
    for (int k = 0; k < 12; k++) step(1'b1);

    // fall interrupted by reset at E4 while q is still 1
    step(1'b0);
    for (int k = 1; k <= 4; k++) step(1'b0);
    chk("midwait_pre", {30'd0, q[0], busy[0]}, 32'd3);
    do_reset();
    for (int k = 0; k < 20; k++) step(1'b0);
    chk("midwait_post_q", 32'(q[0]), 32'd0);

    // reset released with input already high: full qualification
    d_in = 1'b1;
    do_reset();
    for (int k = 0; k < 20; k++) step(1'b1);
    chk("rel_high_q", 32'(q[0]), 32'd1);

    // randomised segments with occasional resets
    v = 1'b1;
    for (int s = 0; s < 200; s++) begin
      v = !v;
      len = (($urandom_range(0, 2)) == 0) ? $urandom_range(10, 24) : $urandom_range(1, 6);
      for (int k = 0; k < len; k++) step(v);
      if ($urandom_range(0, 24) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
